// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types for the 1RW SRAM initiator controller.
// Holds the sweep/run state encoding.
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/hpdcache_sram_1rw_ctrl_if.sv
// Request/response handshake bundle between cache datapath
// and the SRAM controller.
interface hpdcache_sram_1rw_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_SIZE-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/hpdcache_sram_rsp_hold.sv
// Read-response hold: bypasses SRAM rdata on the first cycle,
// captures it on backpressure so the payload stays stable.
module hpdcache_sram_rsp_hold #(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inflight,
  input  logic [DATA_SIZE-1:0] i_rdata,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_valid,
  output logic [DATA_SIZE-1:0] o_rsp_data
);

  logic                 r_hold_valid;
  logic [DATA_SIZE-1:0] r_hold_data;

  assign o_rsp_valid = i_inflight | r_hold_valid;
  assign o_rsp_data  = r_hold_valid ? r_hold_data : i_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      if (o_rsp_valid && i_rsp_ready) begin
        r_hold_valid <= 1'b0;
      end else if (o_rsp_valid) begin
        r_hold_valid <= 1'b1;
      end
      if (i_inflight && !r_hold_valid && !i_rsp_ready) begin
        r_hold_data <= i_rdata;
      end
    end
  end

endmodule

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// Single-port SRAM initiator: request/response handshake,
// one-cycle read latency, and a post-reset clear sweep.
module hpdcache_sram_1rw_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE   = 6,
  parameter int unsigned          DATA_SIZE   = 64,
  parameter int unsigned          DEPTH       = 2**ADDR_SIZE,
  parameter bit                   INIT_ENABLE = 1'b1,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_init_req,
  output logic                 o_init_done,
  hpdcache_sram_1rw_ctrl_if.slave bus,
  output logic                 o_sram_cs,
  output logic                 o_sram_we,
  output logic [ADDR_SIZE-1:0] o_sram_addr,
  output logic [DATA_SIZE-1:0] o_sram_wdata,
  input  logic [DATA_SIZE-1:0] i_sram_rdata
);

  localparam ctrl_state_e RST_STATE = INIT_ENABLE ? ST_INIT : ST_RUN;
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic [ADDR_SIZE-1:0] w_cnt_nxt;
  logic                 r_inflight;
  logic                 w_run;
  logic                 w_rsp_valid;
  logic                 w_init_go;
  logic                 w_req_ready;
  logic                 w_hs;

  assign w_run = (r_state == ST_RUN);

  // Re-clear only on an idle cycle: no response owed, no request pending
  assign w_init_go = INIT_ENABLE && w_run && i_init_req
                  && !w_rsp_valid && !bus.req_valid;

  assign w_req_ready = w_run && !(w_rsp_valid && !bus.rsp_ready)
                    && !w_init_go;
  assign w_hs        = bus.req_valid && w_req_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign o_init_done   = w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RST_STATE;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_inflight <= w_hs && !bus.req_we;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_INIT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_SIZE'(1);
        end
      end
      ST_RUN: begin
        if (w_init_go) w_state_nxt = ST_INIT;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    o_sram_cs    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (!w_run) begin
      o_sram_cs    = 1'b1;
      o_sram_we    = 1'b1;
      o_sram_addr  = r_cnt;
      o_sram_wdata = INIT_VALUE;
    end else if (w_hs) begin
      o_sram_cs    = 1'b1;
      o_sram_we    = bus.req_we;
      o_sram_addr  = bus.req_addr;
      o_sram_wdata = bus.req_wdata;
    end
  end

  hpdcache_sram_rsp_hold #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rsp_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inflight  (r_inflight),
    .i_rdata     (i_sram_rdata),
    .i_rsp_ready (bus.rsp_ready),
    .o_rsp_valid (w_rsp_valid),
    .o_rsp_data  (bus.rsp_data)
  );

  a_addr_in_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    w_hs |-> (32'(bus.req_addr) < DEPTH)
  );

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// Self-checking bench: vector table, stall/init/reset sequences,
// and a randomized run against a memory + response-queue model.
module tb_hpdcache_sram_1rw_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 16;
  localparam logic [DW-1:0] IV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req;
  logic init_done;
  logic sram_cs;
  logic sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int total = 0;
  int bad = 0;

  hpdcache_sram_1rw_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  hpdcache_sram_1rw_ctrl #(
    .ADDR_SIZE   (AW),
    .DATA_SIZE   (DW),
    .DEPTH       (DEP),
    .INIT_ENABLE (1'b1),
    .INIT_VALUE  (IV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_init_req   (init_req),
    .o_init_done  (init_done),
    .bus          (bus),
    .o_sram_cs    (sram_cs),
    .o_sram_we    (sram_we),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model; rdata wanders when not being read
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
    else sram_rdata <= $urandom;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < DEP; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      chk({nm, "_cs"}, {sram_cs, sram_we}, 2'b11);
      chk({nm, "_addr"}, sram_addr, i);
      chk({nm, "_wdata"}, sram_wdata, IV);
      chk({nm, "_busy"}, {init_done, bus.req_ready}, 2'b00);
    end
    cyc();
    @(negedge clk);
    chk({nm, "_done"}, init_done, 1'b1);
    chk({nm, "_rdy"}, bus.req_ready, 1'b1);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rsp;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[10];
  logic [DW-1:0] ref_mem [DEP];
  logic [DW-1:0] exp_q [$];

  initial begin
    tbl[0] = '{1'b1, 5'd3, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 5'd3, 32'h0, 1'b1, 32'h1234_5678};
    tbl[2] = '{1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 5'd9, 32'h0, 1'b1, IV};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, IV};
    tbl[5] = '{1'b1, 5'd1, 32'h0000_1111, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, IV};
    tbl[7] = '{1'b0, 5'd1, 32'h0, 1'b1, 32'h0000_1111};
    tbl[8] = '{1'b0, 5'd2, 32'h0, 1'b1, IV};
    tbl[9] = '{1'b0, 5'd5, 32'h0, 1'b1, 32'hA5A5_A5A5};

    init_req = 1'b0;
    bus.rsp_ready = 1'b1;
    idle();

    // reset and power-up sweep
    #12;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    cyc();
    rst_n = 1'b1;
    sweep("sweep0");

    // vector table, pipelined one request per cycle
    for (int i = 0; i <= 10; i++) begin
      cyc();
      if (i < 10) drive(tbl[i].we, tbl[i].addr, tbl[i].wd);
      else idle();
      @(negedge clk);
      if (i < 10) begin
        chk("tbl_ready", bus.req_ready, 1'b1);
        chk("tbl_strobe", {sram_cs, sram_we, sram_addr},
            {1'b1, tbl[i].we, tbl[i].addr});
      end
      if (i > 0) begin
        chk("tbl_rsp_valid", bus.rsp_valid, tbl[i-1].rsp);
        if (tbl[i-1].rsp) chk("tbl_rsp_data", bus.rsp_data, tbl[i-1].exp);
      end
    end

    // stalled response
    cyc();
    drive(1'b0, 5'd5, '0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_acc", bus.req_ready, 1'b1);
    cyc();
    drive(1'b0, 5'd0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_data", bus.rsp_data, 32'hA5A5_A5A5);
      chk("stall_ready", {bus.req_ready, sram_cs}, 2'b00);
    end
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_rel_data", {bus.rsp_valid, bus.rsp_data},
        {1'b1, 32'hA5A5_A5A5});
    chk("stall_rel_ready", {bus.req_ready, sram_cs}, 2'b11);
    cyc();
    idle();
    @(negedge clk);
    chk("stall_next", {bus.rsp_valid, bus.rsp_data}, {1'b1, IV});
    cyc();
    @(negedge clk);
    chk("stall_single", bus.rsp_valid, 1'b0);

    // init_req deferred behind a stalled response
    cyc();
    drive(1'b0, 5'd1, '0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("ireq_acc", bus.req_ready, 1'b1);
    cyc();
    idle();
    init_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("ireq_wait", {init_done, bus.rsp_valid, sram_cs}, 3'b110);
      chk("ireq_data", bus.rsp_data, 32'h0000_1111);
    end
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("ireq_hs", {init_done, bus.rsp_valid}, 2'b11);
    cyc();
    @(negedge clk);
    chk("ireq_go", {init_done, bus.rsp_valid, bus.req_ready}, 3'b100);
    cyc();
    init_req = 1'b0;
    sweep("sweep1");
    for (int j = 0; j <= DEP; j++) begin
      cyc();
      if (j < DEP) drive(1'b0, AW'(j), '0);
      else idle();
      @(negedge clk);
      if (j > 0) chk("clr_read", {bus.rsp_valid, bus.rsp_data}, {1'b1, IV});
    end

    // async reset at sweep address 7
    cyc();
    idle();
    init_req = 1'b1;
    @(negedge clk);
    chk("rst2_go", bus.req_ready, 1'b0);
    cyc();
    init_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      chk("rst2_addr", sram_addr, i);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_async", {init_done, bus.rsp_valid, bus.req_ready}, 3'b000);
    chk("rst2_addr0", sram_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sweep("sweep2");

    // randomized traffic vs memory + response-queue model
    for (int i = 0; i < DEP; i++) ref_mem[i] = IV;
    for (int n = 0; n < 400; n++) begin
      logic exp_rv;
      logic exp_rdy;
      logic exp_hs;
      cyc();
      if ($urandom_range(0, 3) != 0) begin
        drive(1'($urandom), AW'($urandom_range(0, DEP - 1)), $urandom);
      end else begin
        idle();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rv  = (exp_q.size() != 0);
      exp_rdy = !(exp_rv && !bus.rsp_ready);
      exp_hs  = bus.req_valid && exp_rdy;
      chk("rnd_rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) chk("rnd_rsp_data", bus.rsp_data, exp_q[0]);
      chk("rnd_req_ready", bus.req_ready, exp_rdy);
      chk("rnd_cs", sram_cs, exp_hs);
      if (exp_hs) chk("rnd_addr", {sram_we, sram_addr},
                      {bus.req_we, bus.req_addr});
      if (exp_rv && bus.rsp_ready) void'(exp_q.pop_front());
      if (exp_hs) begin
        if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
        else exp_q.push_back(ref_mem[bus.req_addr]);
      end
    end
    cyc();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_1rw_ctrl.md
Name: hpdcache_sram_1rw_ctrl

Overview:
Initiator-side controller for a single-port 1RW SRAM macro with one-cycle read latency. It converts a valid/ready request stream into SRAM cs/we/addr/wdata strobes and returns read data on a valid/ready response channel, holding the data under backpressure. It also clears the whole array to a constant after reset, and again on request. It sits between cache datapath logic and the data/tag SRAMs.

Parameters:
ADDR_SIZE, 6, SRAM address width
DATA_SIZE, 64, SRAM word width
DEPTH, 2**ADDR_SIZE, number of words; may be non-power-of-2, must be <= 2**ADDR_SIZE
INIT_ENABLE, 1, 1: sweep-clear after reset and on init_req; 0: no sweep
INIT_VALUE, '0, DATA_SIZE-bit word written during the sweep

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
init_req  in  1  request a runtime re-clear (level; sampled in RUN only)
init_done  out  1  1 when not sweeping
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1 write, 0 read
req_addr  in  ADDR_SIZE  word address
req_wdata  in  DATA_SIZE  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts rsp
rsp_data  out  DATA_SIZE  read data
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_SIZE  SRAM address
sram_wdata  out  DATA_SIZE  SRAM write data
sram_rdata  in  DATA_SIZE  SRAM read data, valid the cycle after a read strobe

Behaviour:
- States: INIT, RUN. Reset value: INIT if INIT_ENABLE, else RUN. Init counter = 0, in-flight flag = 0, hold_valid = 0. Resulting outputs at reset: rsp_valid=0, req_ready=0 in INIT, init_done=!INIT_ENABLE.
- INIT: each cycle sram_cs=1, sram_we=1, sram_addr=counter, sram_wdata=INIT_VALUE; counter increments. After the write to DEPTH-1, go to RUN and clear the counter. Sweep lasts exactly DEPTH cycles. init_done=0 and req_ready=0 throughout.
- RUN strobes are combinational from the request: sram_cs = req_valid&req_ready, sram_we = req_we, sram_addr = req_addr, sram_wdata = req_wdata. When sram_cs=0, the values of sram_we/addr/wdata are don't-care but must be driven to 0.
- req_ready = (state==RUN) & !(rsp_valid & !rsp_ready). This is a combinational path from rsp_ready; it is intended.
- Read accepted at cycle T: in-flight=1 at T+1, rsp_valid=1 at T+1, and rsp_data=sram_rdata (bypass).
- If rsp_valid & !rsp_ready: capture rsp_data into the hold register and set hold_valid. While hold_valid=1, rsp_data comes from the hold register, so it stays stable even if SRAM rdata changes.
- rsp_valid = in-flight | hold_valid. A handshake clears both. A new read accepted in the same cycle as the handshake sets in-flight again, giving back-to-back reads at 1/cycle with rsp_ready=1.
- Writes produce no response.
- Read of address A in the cycle after a write to A returns the new data.
- init_req in RUN is honoured only when rsp_valid=0 and no request is handshaking that cycle. req_ready is forced 0 in that cycle; next state is INIT. Otherwise the request stays pending (level).
- INIT_ENABLE=0: init_req is ignored and init_done is tied to 1.
- Async reset mid-sweep or mid-response: all state is cleared immediately and any outstanding response is dropped. After rst_n rises the sweep restarts from address 0.
- Out-of-range req_addr (>= DEPTH) is passed through unchanged. An SVA assertion flags it in simulation.

Decomposition:
- hpdcache_sram_ctrl_pkg: state enum (INIT, RUN).
- The response hold register (bypass mux + capture) is a natural sub-module: hpdcache_sram_rsp_hold, parameterised by DATA_SIZE.
- The top module contains the FSM, the init counter and the strobe muxing. The SRAM macro is instantiated by the integrator, outside this block.

Test Plan:
- Reset, DEPTH=16, INIT_VALUE=32'hDEAD_BEEF -> 16 consecutive write strobes to addresses 0..15. init_done rises in cycle 17. A subsequent read of address 9 returns 32'hDEAD_BEEF.
- Write 32'h1234_5678 to address 3, then read address 3 in the next cycle -> rsp_valid one cycle after the read is accepted, rsp_data=32'h1234_5678.
- Back-to-back reads of addresses 0,1,2 with rsp_ready=1 -> req_ready stays 1 and three responses arrive on consecutive cycles, in order.
- Read address 5 (holding 32'hA5A5_A5A5) with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stay constant and req_ready=0. When rsp_ready=1 there is a single handshake and req_ready returns to 1.
- init_req asserted while a response is stalled -> no sweep until the response handshakes. The sweep then runs 16 cycles and all words read back INIT_VALUE.
- rst_n pulsed low at sweep address 7 -> outputs return to reset values asynchronously. The sweep restarts at address 0 and completes all 16 writes.
